// File: rtl/div_sequencer.sv
// Queues divide requests, issues them one at a time to a multi-cycle divider and
// returns results in order. Define DIV_ZERO_CHECK_EN to bypass zero-divisor requests.
module div_sequencer #(
  parameter int WIDTH = 256,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_dividend,
  input  logic [WIDTH-1:0] in_divisor,
  output logic             div_start,
  output logic [WIDTH-1:0] div_dividend,
  output logic [WIDTH-1:0] div_divisor,
  input  logic             div_ready,
  input  logic [WIDTH-1:0] div_quotient,
  input  logic [WIDTH-1:0] div_remainder,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_quotient,
  output logic [WIDTH-1:0] out_remainder,
  output logic             out_err,
  // FSM state for observation: 0=IDLE 1=ISSUE 2=WAIT 3=OUT
  output logic [1:0]       fsm_state
);

  // Handshakes: a request transfers on a rising edge where in_valid && in_ready,
  // a result on a rising edge where out_valid && out_ready; valid never waits on ready.

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    OUT   = 2'd3
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] mem_dividend [DEPTH];
  logic [WIDTH-1:0] mem_divisor  [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count, count_next;
  logic [WIDTH-1:0] head_dividend, head_divisor;

  logic push, pop, load_ops, capture, bypass, wait_first, result_free;

  assign push          = in_valid && in_ready;
  assign head_dividend = mem_dividend[rd_ptr];
  assign head_divisor  = mem_divisor[rd_ptr];
  assign result_free   = !out_valid || out_ready;
  assign div_start     = (state == ISSUE);
  assign fsm_state     = state;

  // Request FIFO storage; contents are don't-care while count says empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_dividend[wr_ptr] <= in_dividend;
      mem_divisor[wr_ptr]  <= in_divisor;
    end
  end

  always_comb begin
    count_next = count;
    if (push && !pop)      count_next = count + 1'b1;
    else if (!push && pop) count_next = count - 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      in_ready <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count    <= count_next;
      // Registered from the next count so downstream readiness never reaches in_ready combinationally.
      in_ready <= (count_next != FULL_CNT);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      wait_first <= 1'b0;
    end else begin
      state      <= state_next;
      wait_first <= (state == ISSUE);
    end
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    load_ops   = 1'b0;
    capture    = 1'b0;
    bypass     = 1'b0;
    case (state)
      IDLE: begin
        if ((count != '0) && result_free) begin
`ifdef DIV_ZERO_CHECK_EN
          if (head_divisor == '0) begin
            bypass     = 1'b1;
            pop        = 1'b1;
            state_next = OUT;
          end else begin
            load_ops   = 1'b1;
            state_next = ISSUE;
          end
`else
          load_ops   = 1'b1;
          state_next = ISSUE;
`endif
        end
      end
      ISSUE: begin
        pop        = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        // The divider may still show the previous result's ready during the first wait cycle.
        if (!wait_first && div_ready) begin
          capture    = 1'b1;
          state_next = OUT;
        end
      end
      OUT: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operands held from the start pulse until the result is captured.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_dividend <= '0;
      div_divisor  <= '0;
    end else if (load_ops) begin
      div_dividend <= head_dividend;
      div_divisor  <= head_divisor;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid     <= 1'b0;
      out_quotient  <= '0;
      out_remainder <= '0;
    end else if (capture) begin
      out_valid     <= 1'b1;
      out_quotient  <= div_quotient;
      out_remainder <= div_remainder;
    end else if (bypass) begin
      out_valid     <= 1'b1;
      out_quotient  <= '1;
      out_remainder <= head_dividend;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef DIV_ZERO_CHECK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         out_err <= 1'b0;
    else if (capture) out_err <= 1'b0;
    else if (bypass)  out_err <= 1'b1;
  end
`else
  assign out_err = 1'b0;
`endif

  a_no_push_full: assert property (@(posedge clk) disable iff (!rst)
    !(push && (count == FULL_CNT)));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst)
    !(pop && (count == '0)));
  a_no_start_in_wait: assert property (@(posedge clk) disable iff (!rst)
    !(div_start && (state == WAIT)));

endmodule

// File: tb/tb_div_sequencer.sv
// Bench for div_sequencer: behavioural divider with variable latency and a stale
// ready after each start, plus an in-order result scoreboard.
module tb_div_sequencer;
  localparam int W = 256;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_dividend = '0, in_divisor = '0;
  logic         div_start;
  logic [W-1:0] div_dividend, div_divisor;
  logic         div_ready;
  logic [W-1:0] div_quotient, div_remainder;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_quotient, out_remainder;
  logic         out_err;
  logic [1:0]   fsm_state;

  int errors = 0;
  int checks = 0;
  int starts = 0;
  int stalls = 0;
  logic prev_start = 1'b0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_r_q[$];
  logic         exp_e_q[$];

  div_sequencer #(.WIDTH(W), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_dividend(in_dividend), .in_divisor(in_divisor),
    .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_ready(div_ready), .div_quotient(div_quotient), .div_remainder(div_remainder),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_quotient(out_quotient), .out_remainder(out_remainder),
    .out_err(out_err), .fsm_state(fsm_state)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  // Divider model: ready level stays at its old value for one cycle after a start.
  logic [W-1:0] m_a, m_b;
  int m_cnt;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_ready <= 1'b0; m_cnt <= 0; m_a <= '0; m_b <= '0;
      div_quotient <= '0; div_remainder <= '0;
    end else if (div_start) begin
      m_a <= div_dividend; m_b <= div_divisor; m_cnt <= $urandom_range(2, 5);
    end else if (m_cnt > 1) begin
      div_ready <= 1'b0; m_cnt <= m_cnt - 1;
    end else if (m_cnt == 1) begin
      div_ready <= 1'b1; m_cnt <= 0;
      if (m_b == '0) begin div_quotient <= '1; div_remainder <= m_a; end
      else begin div_quotient <= m_a / m_b; div_remainder <= m_a % m_b; end
    end
  end

  // Scoreboard: compare every accepted result against the expected queue.
  always @(negedge clk) begin
    if (div_start) begin
      starts++;
      checks++;
      if (prev_start) begin errors++; $display("FAIL start_pulse_width: div_start high two cycles in a row"); end
    end
    prev_start = div_start;
    if (rst && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++; $display("FAIL unexpected_result: q=%0d r=%0d with empty queue", out_quotient, out_remainder);
      end else begin
        logic [W-1:0] eq, er; logic ee;
        eq = exp_q.pop_front(); er = exp_r_q.pop_front(); ee = exp_e_q.pop_front();
        if (out_quotient !== eq || out_remainder !== er || out_err !== ee) begin
          errors++;
          $display("FAIL result: got q=%0d r=%0d err=%0b, expected q=%0d r=%0d err=%0b",
                   out_quotient, out_remainder, out_err, eq, er, ee);
        end
      end
    end
  end

  // Driver: present one request, wait for acceptance, record the expected result.
  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b);
    int t = 0;
    in_valid = 1'b1; in_dividend = a; in_divisor = b;
    @(negedge clk);
    while (!in_ready && t < 300) begin stalls++; t++; @(negedge clk); end
    checks++;
    if (!in_ready) begin
      errors++; $display("FAIL push_timeout: in_ready=%0b, required 1", in_ready);
    end else if (b == '0) begin
      exp_q.push_back('1); exp_r_q.push_back(a);
`ifdef DIV_ZERO_CHECK_EN
      exp_e_q.push_back(1'b1);
`else
      exp_e_q.push_back(1'b0);
`endif
    end else begin
      exp_q.push_back(a / b); exp_r_q.push_back(a % b); exp_e_q.push_back(1'b0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int t = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || out_valid) && t < budget) begin t++; @(negedge clk); end
    checks++;
    if (exp_q.size() != 0 || out_valid) begin
      errors++; $display("FAIL drain_timeout: pending=%0d out_valid=%0b, required 0/0", exp_q.size(), out_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; #2; rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || div_start !== 1'b0 || out_err !== 1'b0) begin
      errors++; $display("FAIL reset_flags: in_ready=%0b out_valid=%0b div_start=%0b out_err=%0b, required 0",
                         in_ready, out_valid, div_start, out_err);
    end
    checks++;
    if (out_quotient !== '0 || out_remainder !== '0 || div_dividend !== '0 || div_divisor !== '0) begin
      errors++; $display("FAIL reset_data: oq=%0d or=%0d dd=%0d dv=%0d, required 0",
                         out_quotient, out_remainder, div_dividend, div_divisor);
    end
    checks++;
    if (fsm_state !== 2'd0) begin errors++; $display("FAIL reset_state: %0d, required 0", fsm_state); end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset: %0b, required 1", in_ready); end
  endtask

  task automatic test_single();
    int s0;
    out_ready = 1'b1; s0 = starts;
    push(100, 10);
    wait_drain(100);
    checks++;
    if (starts - s0 != 1) begin errors++; $display("FAIL single_starts: %0d, required 1", starts - s0); end
  endtask

  task automatic test_back_to_back();
    int s0, st0;
    out_ready = 1'b1; s0 = starts; st0 = stalls;
    push(100, 10); push(123, 7); push(255, 16); push(9, 3);
    checks++;
    if (stalls != st0) begin errors++; $display("FAIL b2b_in_ready: stalled %0d cycles, required 0", stalls - st0); end
    wait_drain(200);
    checks++;
    if (starts - s0 != 4) begin errors++; $display("FAIL b2b_starts: %0d, required 4", starts - s0); end
  endtask

  task automatic test_backpressure();
    int s0, t;
    logic [W-1:0] hq, hr;
    out_ready = 1'b0; s0 = starts;
    push(1000, 3); push(77, 5); push(64, 8); push(99, 10); push(500, 7);
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full: in_ready=%0b, required 0", in_ready); end
    t = 0;
    while (!out_valid && t < 100) begin t++; @(negedge clk); end
    hq = exp_q[0]; hr = exp_r_q[0];
    repeat (10) @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_quotient !== hq || out_remainder !== hr) begin
      errors++; $display("FAIL bp_hold: valid=%0b q=%0d r=%0d, required 1 q=%0d r=%0d",
                         out_valid, out_quotient, out_remainder, hq, hr);
    end
    checks++;
    if (starts - s0 != 1 || in_ready !== 1'b0) begin
      errors++; $display("FAIL bp_in_flight: starts=%0d in_ready=%0b, required 1 and 0", starts - s0, in_ready);
    end
    @(posedge clk); #1; out_ready = 1'b1;
    wait_drain(300);
    checks++;
    if (starts - s0 != 5) begin errors++; $display("FAIL bp_starts: %0d, required 5", starts - s0); end
  endtask

  task automatic test_div_zero();
    int s0, want;
    out_ready = 1'b1; s0 = starts;
`ifdef DIV_ZERO_CHECK_EN
    want = 0;
`else
    want = 1;
`endif
    push(7, 0);
    wait_drain(100);
    checks++;
    if (starts - s0 != want) begin errors++; $display("FAIL zero_starts: %0d, required %0d", starts - s0, want); end
  endtask

  task automatic test_mid_reset();
    int t = 0, s0;
    bit seen_valid = 0;
    out_ready = 1'b1;
    push(123, 7); push(100, 10); push(9, 3);
    @(negedge clk);
    while (fsm_state != 2'd2 && t < 50) begin t++; @(negedge clk); end
    checks++;
    if (fsm_state !== 2'd2) begin errors++; $display("FAIL mid_reach_wait: state=%0d, required 2", fsm_state); end
    rst = 1'b0; #1;
    exp_q.delete(); exp_r_q.delete(); exp_e_q.delete();
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || div_start !== 1'b0 || out_err !== 1'b0 ||
        fsm_state !== 2'd0 || out_quotient !== '0 || out_remainder !== '0 ||
        div_dividend !== '0 || div_divisor !== '0) begin
      errors++; $display("FAIL mid_reset_outputs: ready=%0b valid=%0b start=%0b err=%0b state=%0d dd=%0d",
                         in_ready, out_valid, div_start, out_err, fsm_state, div_dividend);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1; s0 = starts;
    repeat (12) begin @(negedge clk); if (out_valid) seen_valid = 1; end
    checks++;
    if (seen_valid || starts != s0) begin
      errors++; $display("FAIL mid_stale: out_valid seen=%0b starts=%0d, required 0 and 0", seen_valid, starts - s0);
    end
    @(posedge clk); #1;
    push(100, 10);
    wait_drain(100);
  endtask

  task automatic test_random();
    bit done = 0;
    fork
      begin
        for (int i = 0; i < 24; i++) push($urandom_range(0, 60000), $urandom_range(0, 400));
        done = 1;
      end
      begin
        while (!done) begin @(posedge clk); #1; out_ready = ($urandom_range(0, 3) != 0); end
      end
    join
    out_ready = 1'b1;
    wait_drain(500);
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_div_zero();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
